// File: rtl/seq_bit_generator.sv
// seq_bit_generator
//
// Serial pattern transmitter. Accepts a parallel word over a load/ready handshake and
// shifts it out MSB-first, one bit per clock, with a valid strobe. It optionally carries a
// golden model of a sequence detector. That model flags every emitted bit that completes
// the latched pattern and counts the matches in each transfer.
//
// Optional feature macro: SEQ_GEN_MATCH_EN
//   defined   : history, fill counter, match and match_cnt logic are built in.
//   undefined : match and match_cnt are tied to 0 and seq is unused.
//
// Parameters
//   WIDTH   maximum word length in bits
//   SEQ_W   pattern length in bits
//   OVERLAP 1 = overlapping match counting, 0 = fill cleared after each match
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   load       in   request to start a transfer (honoured only while ready)
//   word       in   data to send, sampled on accept
//   len        in   bits to send; 0 or anything above WIDTH means WIDTH
//   seq        in   pattern, sampled on accept
//   ready      out  high only in IDLE
//   dout       out  serial data bit
//   dvalid     out  dout is a valid stream bit
//   match      out  current dout bit completes the pattern
//   done       out  one-cycle pulse after the last bit
//   match_cnt  out  matches in the current or last transfer, saturating
//
// All outputs are registered.
module seq_bit_generator #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SEQ_W   = 4,
  parameter bit          OVERLAP = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [WIDTH-1:0]           word,
  input  logic [$clog2(WIDTH):0]     len,
  input  logic [SEQ_W-1:0]           seq,
  output logic                       ready,
  output logic                       dout,
  output logic                       dvalid,
  output logic                       match,
  output logic                       done,
  output logic [$clog2(WIDTH):0]     match_cnt
);

  localparam int unsigned LenW = $clog2(WIDTH) + 1;
  localparam logic [LenW-1:0] WidthL = LenW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;    // bits still to emit after the one on dout
  logic [LenW-1:0]  cnt_q, cnt_d;      // bits left, including the one on dout
  logic             dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic [LenW-1:0]  eff_len;
  logic [LenW-1:0]  shamt;
  logic [WIDTH-1:0] aligned;

  // A bit is put on dout at the coming edge. first marks the first bit of a transfer.
  logic             bit_fire;
  logic             bit_val;
  logic             first;

  always_comb begin
    eff_len = len;
    if (len == '0 || len > WidthL) eff_len = WidthL;
    shamt   = WidthL - eff_len;
    // Left-justify so that bit len-1 of the word lands on the MSB.
    aligned = word << shamt;
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    dout_d   = 1'b0;
    dvalid_d = 1'b0;
    done_d   = 1'b0;
    ready_d  = 1'b0;
    bit_fire = 1'b0;
    bit_val  = 1'b0;
    first    = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (load) begin
          state_d  = StShift;
          ready_d  = 1'b0;
          dout_d   = aligned[WIDTH-1];
          dvalid_d = 1'b1;
          sreg_d   = aligned << 1;
          cnt_d    = eff_len;
          bit_fire = 1'b1;
          bit_val  = aligned[WIDTH-1];
          first    = 1'b1;
        end
      end
      StShift: begin
        if (cnt_q == LenW'(1)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          dout_d   = sreg_q[WIDTH-1];
          dvalid_d = 1'b1;
          sreg_d   = sreg_q << 1;
          cnt_d    = cnt_q - LenW'(1);
          bit_fire = 1'b1;
          bit_val  = sreg_q[WIDTH-1];
        end
      end
      StDone: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      sreg_q   <= '0;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign ready  = ready_q;
  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign done   = done_q;

`ifdef SEQ_GEN_MATCH_EN
  localparam int unsigned FillW = $clog2(SEQ_W + 1);

  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [SEQ_W-1:0] hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             match_q, match_d;
  logic [LenW-1:0]  mcnt_q, mcnt_d;

  logic [SEQ_W-1:0] seq_cur;
  logic [SEQ_W-1:0] hist_base;
  logic [FillW-1:0] fill_base;
  logic [LenW-1:0]  mcnt_base;

  always_comb begin
    // On accept the model starts from a clean slate with the incoming pattern, so the
    // first bit is judged in the same cycle it is emitted.
    seq_cur   = first ? seq : seq_q;
    hist_base = first ? '0 : hist_q;
    fill_base = first ? '0 : fill_q;
    mcnt_base = first ? '0 : mcnt_q;

    seq_d   = seq_cur;
    hist_d  = hist_q;
    fill_d  = fill_q;
    mcnt_d  = mcnt_q;
    match_d = 1'b0;
    if (bit_fire) begin
      hist_d  = (hist_base << 1) | SEQ_W'(bit_val);
      fill_d  = (fill_base == FillW'(SEQ_W)) ? fill_base : fill_base + FillW'(1);
      match_d = (hist_d == seq_cur) && (fill_d == FillW'(SEQ_W));
      mcnt_d  = mcnt_base;
      if (match_d) begin
        if (mcnt_base != '1) mcnt_d = mcnt_base + LenW'(1);
        if (!OVERLAP) fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      mcnt_q  <= '0;
    end else begin
      seq_q   <= seq_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = mcnt_q;
`else
  logic unused_match_cfg;
  assign unused_match_cfg = ^{seq, first, bit_fire, bit_val, OVERLAP};

  assign match     = 1'b0;
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_bit_generator.sv
module tb_seq_bit_generator;

`ifdef SEQ_GEN_MATCH_EN
  localparam bit MatchEn = 1'b1;
`else
  localparam bit MatchEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] word;
  logic [5:0]  len;
  logic [3:0]  seq;

  logic       ready_a, dout_a, dvalid_a, match_a, done_a;
  logic [5:0] mcnt_a;
  logic       ready_b, dout_b, dvalid_b, match_b, done_b;
  logic [5:0] mcnt_b;

  // a: overlapping counting, b: non-overlapping; both see identical stimulus.
  seq_bit_generator #(.WIDTH(32), .SEQ_W(4), .OVERLAP(1'b1)) dut_a (
    .clk(clk), .reset(reset), .load(load), .word(word), .len(len), .seq(seq),
    .ready(ready_a), .dout(dout_a), .dvalid(dvalid_a), .match(match_a), .done(done_a),
    .match_cnt(mcnt_a)
  );

  seq_bit_generator #(.WIDTH(32), .SEQ_W(4), .OVERLAP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .load(load), .word(word), .len(len), .seq(seq),
    .ready(ready_b), .dout(dout_b), .dvalid(dvalid_b), .match(match_b), .done(done_b),
    .match_cnt(mcnt_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the emitted bit list and the match flags, worked out from the
  // pattern-window rules over the whole list.
  bit mbits[32];
  bit mov[32];
  bit mno[32];
  int mn;
  int cov;
  int cno;

  task automatic build_model(input logic [31:0] w, input logic [5:0] l, input logic [3:0] s);
    int start;
    bit hit;
    mn = (l == 0 || l > 32) ? 32 : int'(l);
    for (int k = 0; k < 32; k++) begin
      mbits[k] = 1'b0;
      mov[k]   = 1'b0;
      mno[k]   = 1'b0;
    end
    for (int k = 0; k < mn; k++) mbits[k] = w[mn-1-k];
    cov   = 0;
    cno   = 0;
    start = 0;
    for (int k = 0; k < mn; k++) begin
      hit = 1'b0;
      if (k >= 3) hit = ({mbits[k-3], mbits[k-2], mbits[k-1], mbits[k]} == s);
      if (MatchEn && hit) begin
        mov[k] = 1'b1;
        cov++;
        if (k >= start + 3) begin
          mno[k] = 1'b1;
          cno++;
          start = k + 1;
        end
      end
    end
  endtask

  // One complete transfer, sampled on negative edges. Starts and ends in a ready cycle.
  task automatic xfer(input logic [31:0] w, input logic [5:0] l, input logic [3:0] s,
                      input int exp_ov, input int exp_no, input bit noise);
    int guard;
    int ro;
    int rn;
    build_model(w, l, s);
    guard = 0;
    while (!ready_a && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_load", {31'd0, ready_a}, 32'd1);
    word = w;
    len  = l;
    seq  = s;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    ro = 0;
    rn = 0;
    for (int k = 0; k < mn; k++) begin
      ro += int'(mov[k]);
      rn += int'(mno[k]);
      chk($sformatf("bit%0d dout_a", k), {31'd0, dout_a}, {31'd0, mbits[k]});
      chk($sformatf("bit%0d dout_b", k), {31'd0, dout_b}, {31'd0, mbits[k]});
      chk($sformatf("bit%0d dvalid", k), {30'd0, dvalid_a, dvalid_b}, 32'd3);
      chk($sformatf("bit%0d match_a", k), {31'd0, match_a}, {31'd0, mov[k]});
      chk($sformatf("bit%0d match_b", k), {31'd0, match_b}, {31'd0, mno[k]});
      chk($sformatf("bit%0d mcnt_a", k), {26'd0, mcnt_a}, ro);
      chk($sformatf("bit%0d mcnt_b", k), {26'd0, mcnt_b}, rn);
      chk($sformatf("bit%0d ready_done", k), {28'd0, ready_a, ready_b, done_a, done_b}, 32'd0);
      if (noise) begin
        load = 1'($urandom_range(0, 1));
        word = $urandom;
        seq  = 4'($urandom);
        len  = 6'($urandom);
      end
      @(negedge clk);
    end
    chk("done_pulse", {30'd0, done_a, done_b}, 32'd3);
    chk("done_quiet", {26'd0, dvalid_a, dvalid_b, dout_a, dout_b, match_a, match_b}, 32'd0);
    chk("done_ready", {30'd0, ready_a, ready_b}, 32'd0);
    chk("done_mcnt_a", {26'd0, mcnt_a}, exp_ov);
    chk("done_mcnt_b", {26'd0, mcnt_b}, exp_no);
    if (noise) begin
      load = 1'b1;
      word = $urandom;
    end
    @(negedge clk);
    load = 1'b0;
    chk("idle_ready", {30'd0, ready_a, ready_b}, 32'd3);
    chk("idle_quiet", {28'd0, done_a, done_b, dvalid_a, dvalid_b}, 32'd0);
    chk("idle_mcnt_a_hold", {26'd0, mcnt_a}, exp_ov);
    chk("idle_mcnt_b_hold", {26'd0, mcnt_b}, exp_no);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [5:0]  len;
    logic [3:0]  seq;
    int          cnt_ov;
    int          cnt_no;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit seen_done;
    logic [31:0] rw;
    logic [5:0]  rl;
    logic [3:0]  rs;

    vecs[0] = '{32'h4BA56BAB, 6'd0,  4'b1010, 5,  4};
    vecs[1] = '{32'h4A95B6DA, 6'd0,  4'b0110, 5,  3};
    vecs[2] = '{32'h0000000A, 6'd4,  4'b1010, 1,  1};
    vecs[3] = '{32'h00000007, 6'd3,  4'b0111, 0,  0};
    vecs[4] = '{32'hFFFFFFFF, 6'd40, 4'b1111, 29, 8};
    vecs[5] = '{32'h0000001F, 6'd5,  4'b1111, 2,  1};
    vecs[6] = '{32'hFFFFFFF0, 6'd4,  4'b0000, 1,  1};

    reset = 1'b1;
    load  = 1'b0;
    word  = '0;
    len   = '0;
    seq   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", {30'd0, ready_a, ready_b}, 32'd3);
    chk("reset_outputs", {26'd0, dout_a, dout_b, dvalid_a, dvalid_b, done_a, done_b}, 32'd0);
    chk("reset_match", {20'd0, match_a, match_b, mcnt_a, mcnt_b}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {28'd0, ready_a, ready_b, dvalid_a, dvalid_b}, 32'd12);

    // Table vectors run back to back; odd entries also toggle load mid-transfer.
    for (int i = 0; i < 7; i++) begin
      xfer(vecs[i].word, vecs[i].len, vecs[i].seq,
           MatchEn ? vecs[i].cnt_ov : 0, MatchEn ? vecs[i].cnt_no : 0, (i % 2) == 1);
    end

    // Reset while bit 10 of a full-width transfer is on dout.
    build_model(32'h4BA56BAB, 6'd0, 4'b1010);
    word = 32'h4BA56BAB;
    len  = 6'd0;
    seq  = 4'b1010;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    chk("abort_bit10", {30'd0, dout_a, dvalid_a}, {30'd0, mbits[10], 1'b1});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", {30'd0, ready_a, ready_b}, 32'd3);
    chk("abort_quiet", {26'd0, dvalid_a, dvalid_b, done_a, done_b, match_a, match_b}, 32'd0);
    chk("abort_mcnt", {20'd0, mcnt_a, mcnt_b}, 32'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_a || done_b || dvalid_a || dvalid_b) seen_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen_done}, 32'd0);

    // Randomized transfers against the model.
    for (int i = 0; i < 40; i++) begin
      rw = $urandom;
      rl = 6'($urandom_range(0, 40));
      rs = 4'($urandom);
      build_model(rw, rl, rs);
      xfer(rw, rl, rs, cov, cno, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_bit_generator.md
# seq_bit_generator

Serial pattern transmitter: accepts a parallel word over a load/ready handshake and shifts it out MSB-first, one bit per clock, with a valid strobe. It drives the `din` input of `sequence_detector` in benches and loopback paths. It also carries a golden model of the detector that flags every emitted bit completing the configured pattern and counts matches per transfer, so a bench can compare both ends cycle by cycle.

## Interface
- `WIDTH`, 32, maximum word length in bits.
- `SEQ_W`, 4, pattern length in bits.
- `OVERLAP`, 1, 1 = overlapping match counting, 0 = non-overlapping (history cleared after each match).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  request to start a transfer.
- `word`  in  WIDTH  data to send, sampled on accept.
- `len`  in  $clog2(WIDTH)+1  number of bits to send; 0 means WIDTH; values above WIDTH clamp to WIDTH.
- `seq`  in  SEQ_W  pattern, sampled on accept.
- `ready`  out  1  high only in IDLE.
- `dout`  out  1  serial data bit.
- `dvalid`  out  1  `dout` is a valid stream bit.
- `match`  out  1  current `dout` bit completes the pattern.
- `done`  out  1  one-cycle pulse after the last bit.
- `match_cnt`  out  $clog2(WIDTH)+1  matches in the current or last transfer, saturating.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE: `ready`=1. When `load`=1, the block latches `word` left-justified to bit `len`-1, plus `len` and `seq`. It then clears the history, fill counter and `match_cnt`, and goes to SHIFT.
- SHIFT: each cycle, `dout` = next MSB and `dvalid`=1, and the bit counter decrements. After the bit with counter = 1, the FSM goes to DONE.
- DONE: held for exactly one cycle. `done`=1, `dvalid`=0, `dout`=0. The FSM then returns to IDLE.
- `load` is ignored in SHIFT and DONE. There is no queueing.
- Match model: a SEQ_W-bit history of emitted bits and a fill counter, both updated with each valid bit.
  - `match`=1 when history including the new bit equals the latched `seq` and fill ≥ SEQ_W.
  - When `match` fires, `match_cnt` increments.
  - If OVERLAP=0, fill resets to 0 on a match.
- Matches never span transfers; history is cleared on accept.
- `len` < SEQ_W is legal; the transfer produces zero matches.
- Reset in any state forces IDLE and aborts the transfer with no `done`. All outputs reset to 0 except `ready`, which resets to 1.

## Timing
- All outputs are registered.
- Load accepted at edge N: first bit on `dout`/`dvalid` in cycle N+1; last bit in cycle N+`len`; `done` in cycle N+`len`+1; `ready` returns in cycle N+`len`+2.
- `match` is aligned to the same cycle as the completing `dout` bit.
- `match_cnt` updates together with `match` and holds its value from `done` until the next accept.
- Back-to-back transfers have a minimum period of `len`+2 cycles.
- A detector clocked on the same edge sees `dout` one cycle after it is driven. The bench compensates by delaying `match` one cycle.

## Configuration
- `SEQ_GEN_MATCH_EN` defined: history, fill counter, `match` and `match_cnt` logic are compiled in as described above.
- `SEQ_GEN_MATCH_EN` undefined: `match` and `match_cnt` are tied to 0, `seq` is unused, and the serializer and handshake are unchanged.

## Test plan
- Reset, then `word`=0x4BA56BAB, `len`=0, `seq`=4'b1010, OVERLAP=1 → 32 bits MSB-first. `match` fires on bits at indices 11, 16, 21, 27, 29 (0 = first bit). `done` at cycle 33 after accept; `match_cnt`=5.
- Same word and pattern with OVERLAP=0 → `match` fires on indices 11, 16, 21, 27; `match_cnt`=4.
- `word`=0x4A95B6DA, `seq`=4'b0110 → OVERLAP=1 gives `match_cnt`=5; OVERLAP=0 gives `match_cnt`=3.
- `word`=0xA, `len`=4, `seq`=4'b1010 → `dout` sequence 1,0,1,0 with `dvalid` high for 4 cycles; `match` on the 4th bit only; `done` at cycle 5; `ready` at cycle 6.
- `load` pulsed during SHIFT and during DONE → ignored, and the stream is unchanged. A new `load` in the `ready` cycle is accepted.
- `reset` asserted at bit 10 of a 32-bit transfer → the next cycle shows `ready`=1 and `dvalid`=`done`=`match`=0; no `done` pulse is ever produced for the aborted transfer.
